// File: rtl/pipe_reg_chain.sv
// Elastic register chain: DEPTH stages of valid/data with per-stage
// backpressure, bubble collapse, synchronous flush and async reset.
module pipe_reg_chain #(
  parameter int               WIDTH   = 5,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           d_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           d_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            valid_d;
  logic [DEPTH-1:0]            free;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [CW-1:0]               count_q;
  logic [CW-1:0]               count_d;

  // A stage is free when it is empty or the stage after it is free; the last stage looks at out_ready.
  always_comb begin : freeChain
    logic chain;
    chain = out_ready;
    free  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain   = ~valid_q[i] | chain;
      free[i] = chain;
    end
  end

  assign in_ready = free[0] & ~flush;

  // Every free stage takes whatever sits upstream (possibly a bubble); flush wipes all valid bits.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = DEPTH - 1; i >= 1; i--) begin
      if (free[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end
    if (free[0]) begin
      valid_d[0] = in_valid & in_ready;
      if (in_valid & in_ready) begin
        data_d[0] = d_in;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // Occupancy is the population of the next valid vector so count moves with valid.
  always_comb begin : popCount
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + CW'(valid_d[i]);
    end
    count_d = acc;
  end

  // State registers; reset empties the chain and reloads every data stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= {DEPTH{RST_VAL}};
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign d_out     = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: queue-of-entries reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pipe_reg_chain;

  localparam int         WIDTH = 5;
  localparam int         DEPTH = 3;
  localparam logic [4:0] RSTV  = 5'h15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] d_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] d_out;
  logic [1:0] count;

  int vecCount = 0;
  int missCount = 0;
  bit checkEn = 1'b0;

  typedef struct {
    logic [4:0] data;
    int         pos;
  } entry_t;

  entry_t     pipe[$];
  logic [4:0] outLog[$];
  logic [4:0] expQ[$];

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RSTV)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .d_in(d_in),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Entries are kept oldest first with their stage position; each moves up if the slot ahead is vacant.
  function automatic bit shiftModel(input bit outR, input bit commit);
    entry_t q[$];
    int     nextOcc;
    bit     vac0;
    q = pipe;
    if (q.size() > 0 && q[0].pos == DEPTH - 1 && outR) void'(q.pop_front());
    nextOcc = DEPTH;
    foreach (q[k]) begin
      if (q[k].pos + 1 < nextOcc && q[k].pos < DEPTH - 1) q[k].pos = q[k].pos + 1;
      nextOcc = q[k].pos;
    end
    vac0 = (q.size() == 0) || (q[q.size()-1].pos != 0);
    if (commit) pipe = q;
    return vac0;
  endfunction

  // Reference model advances on each edge and is emptied by reset at once.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe.delete();
    end else begin
      entry_t e;
      bit     vac;
      vac = shiftModel(out_ready, 1'b1);
      if (flush) begin
        pipe.delete();
      end else if (in_valid && vac) begin
        e.data = d_in;
        e.pos  = 0;
        pipe.push_back(e);
      end
    end
  end

  // Record every entry that actually leaves the block.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) outLog.push_back(d_out);
  end

  // Per-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      bit expValid;
      expValid = (pipe.size() > 0) && (pipe[0].pos == DEPTH - 1);
      checkOutput("cmp_count", 64'(count), 64'(pipe.size()));
      checkOutput("cmp_out_valid", 64'(out_valid), 64'(expValid));
      if (expValid) checkOutput("cmp_d_out", 64'(d_out), 64'(pipe[0].data));
      checkOutput("cmp_in_ready", 64'(in_ready), 64'(shiftModel(out_ready, 1'b0) && !flush));
    end
  end

  task automatic applyStimulus(input logic iv, input logic [4:0] d, input logic ordy,
                               input logic fl, input int expRdy);
    in_valid  = iv;
    d_in      = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (expRdy >= 0) checkOutput("in_ready_lit", 64'(in_ready), 64'(expRdy));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, -1);
  endtask

  task automatic checkLog(input string name);
    checkOutput({name, "_len"}, 64'(outLog.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < outLog.size(); i++)
      checkOutput(name, 64'(outLog[i]), 64'(expQ[i]));
    outLog.delete();
    expQ.delete();
  endtask

  initial begin
    #1 rst = 1'b1;
    #21;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_d_out", 64'(d_out), 64'(RSTV));
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    checkEn = 1'b1;
    @(posedge clk);
    #1;

    // Single entry latency through an empty chain.
    applyStimulus(1'b1, 5'h0A, 1'b1, 1'b0, 1);
    checkOutput("lat_e0_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, -1);
    checkOutput("lat_e1_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 5'h00, 1'b1, 1'b0, -1);
    checkOutput("lat_e2_valid", 64'(out_valid), 64'd1);
    checkOutput("lat_e2_data", 64'(d_out), 64'h0A);
    drain(1);
    expQ = '{5'h0A};
    checkLog("lat_log");

    // Back-to-back stream at full throughput.
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 5'(k), 1'b1, 1'b0, 1);
    drain(3);
    for (int k = 1; k <= 8; k++) expQ.push_back(5'(k));
    checkLog("stream_log");

    // Backpressure fills the chain, then drains in order.
    applyStimulus(1'b1, 5'h11, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 5'h12, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 5'h13, 1'b0, 1'b0, 1);
    checkOutput("bp_count_full", 64'(count), 64'd3);
    checkOutput("model_count_full", 64'(pipe.size()), 64'd3);
    applyStimulus(1'b1, 5'h14, 1'b0, 1'b0, 0);
    checkOutput("bp_count_hold", 64'(count), 64'd3);
    checkOutput("bp_d_out_hold", 64'(d_out), 64'h11);
    applyStimulus(1'b1, 5'h14, 1'b1, 1'b0, 1);
    drain(3);
    expQ = '{5'h11, 5'h12, 5'h13, 5'h14};
    checkLog("bp_log");

    // Full chain: push and pop in the same cycle.
    applyStimulus(1'b1, 5'h05, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 5'h06, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 5'h07, 1'b0, 1'b0, 1);
    checkOutput("sim_count_before", 64'(count), 64'd3);
    applyStimulus(1'b1, 5'h1F, 1'b1, 1'b0, 1);
    checkOutput("sim_count_after", 64'(count), 64'd3);
    checkOutput("sim_d_out", 64'(d_out), 64'h06);
    drain(3);
    expQ = '{5'h05, 5'h06, 5'h07, 5'h1F};
    checkLog("sim_log");

    // Flush with two entries in flight and one offered.
    applyStimulus(1'b1, 5'h02, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 5'h03, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 5'h09, 1'b1, 1'b1, 0);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("model_count_flush", 64'(pipe.size()), 64'd0);
    drain(3);
    checkLog("flush_log");

    // Asynchronous reset between edges with two entries held.
    applyStimulus(1'b1, 5'h04, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 5'h08, 1'b0, 1'b0, 1);
    checkOutput("arst_count_before", 64'(count), 64'd2);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_count", 64'(count), 64'd0);
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_d_out", 64'(d_out), 64'(RSTV));
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 5'h0C, 1'b1, 1'b0, 1);
    drain(3);
    expQ = '{5'h0C};
    checkLog("arst_log");

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 5: data width in bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 3: number of register stages; legal range 1..8.
REQ-003 Parameter RST_VAL, default 0: WIDTH-bit value loaded into every data stage on reset.
REQ-004 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  in  1: reset, asynchronous, active-high.
REQ-006 Port flush  in  1: synchronous clear of all in-flight entries.
REQ-007 Port in_valid  in  1: upstream presents d_in.
REQ-008 Port in_ready  out  1: block accepts d_in this cycle.
REQ-009 Port d_in  in  WIDTH: input data.
REQ-010 Port out_valid  out  1: d_out holds a valid entry.
REQ-011 Port out_ready  in  1: downstream consumes d_out this cycle.
REQ-012 Port d_out  out  WIDTH: data of the last stage, stage DEPTH-1.
REQ-013 Port count  out  $clog2(DEPTH+1): number of valid stages.

Function
REQ-014 Each stage i (0..DEPTH-1) SHALL hold data[i] and valid[i]; stage 0 is the input stage; stage DEPTH-1 drives d_out and out_valid.
REQ-015 Stage DEPTH-1 SHALL be "free" when valid[DEPTH-1]=0 or out_ready=1.
REQ-016 Stage i<DEPTH-1 SHALL be free when valid[i]=0 or stage i+1 is free.
REQ-017 in_ready SHALL equal (stage 0 free) AND NOT flush, combinationally.
REQ-018 Input transfer SHALL occur on an edge where in_valid=1 and in_ready=1; data[0] is loaded with d_in and valid[0] is set.
REQ-019 Output transfer SHALL occur on an edge where out_valid=1 and out_ready=1; the entry leaves the block.
REQ-020 A valid entry in stage i SHALL move to stage i+1 on an edge where stage i+1 is free; a freed stage with no incoming entry SHALL clear its valid bit (bubble collapse).
REQ-021 A stage that is not free SHALL hold data and valid unchanged.
REQ-022 Entries SHALL never be dropped, duplicated or reordered, except by flush or rst.
REQ-023 Latency: with the block empty and out_ready=1, an entry accepted at edge N SHALL appear with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles after d_in is presented.
REQ-024 Throughput SHALL be one entry per cycle while in_valid=1 and out_ready=1.
REQ-025 Full (count=DEPTH) with out_ready=1: simultaneous input and output transfer SHALL be permitted; count remains DEPTH.
REQ-026 Full with out_ready=0: in_ready SHALL be 0 and all stages SHALL hold.
REQ-027 flush=1 SHALL clear every valid bit on the next edge, with priority over all transfers; an output transfer in the flush cycle still counts as consumed; the data registers need not change.
REQ-028 count SHALL be registered, equal the population of valid[], and update in the same edge as valid[].
REQ-029 d_out SHALL be data[DEPTH-1] regardless of out_valid.
REQ-030 DEPTH=1 SHALL behave as a single register with in_ready = (NOT valid[0] OR out_ready) AND NOT flush.

Reset
REQ-031 On rst=1, immediately and independently of clk: all valid bits = 0, all data = RST_VAL, count = 0, out_valid = 0, d_out = RST_VAL.
REQ-032 While rst=1, no transfer SHALL occur; in_ready SHALL follow REQ-017 on the cleared state.
REQ-033 Reset asserted mid-operation SHALL discard all entries; the first edge after deassertion SHALL behave as if the block is empty.

Verification
REQ-034 DEPTH=3, WIDTH=5, empty, out_ready=1: present 5'h0A at edge 0 -> out_valid=1 and d_out=5'h0A after edge 2, with out_valid=0 before that.
REQ-035 Stream 5'h01..5'h08 on consecutive cycles with out_ready=1 -> outputs 01..08 in order on consecutive cycles; in_ready stays 1.
REQ-036 out_ready=0, push 4 entries 11,12,13,14 -> first three accepted, count=3, in_ready=0 on the fourth; raise out_ready -> 11,12,13 then 14 out in order with no loss.
REQ-037 Full with out_ready=0: push 1F and raise out_ready in the same cycle -> simultaneous transfer, count stays 3, 1F appears after the prior entries.
REQ-038 Two entries in flight, pulse flush one cycle with in_valid=1 -> in_ready=0 in that cycle, count=0 and out_valid=0 after the edge, the offered entry is not captured.
REQ-039 Assert rst asynchronously between edges with count=2 -> count=0, out_valid=0 and d_out=RST_VAL before the next clk edge; after release, normal accept resumes.
